// File: rtl/vga_pkg.sv
// Shared types, default timing and width helper for the VGA sync receiver.
package vga_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } vga_rx_state_t;

  localparam int VGA_TOTAL_COLS  = 800;
  localparam int VGA_TOTAL_ROWS  = 525;
  localparam int VGA_ACTIVE_COLS = 640;
  localparam int VGA_ACTIVE_ROWS = 480;

  function automatic int vga_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_sync_edge_det.sv
// Rise/fall detector for one sync input; the previous-value flop resets high so an
// input already asserted at reset release does not register as a rise.
module vga_sync_edge_det (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Sync,
  output logic o_Rise,
  output logic o_Fall
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = i_Sync;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) prev_q <= 1'b1;
    else          prev_q <= prev_d;
  end

  assign o_Rise = i_Sync & ~prev_q;
  assign o_Fall = ~i_Sync & prev_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// Flywheel receiver recovering column/row, active video and lock from region-style syncs.
// Define VGA_RX_MEASURE_EN to build the free-running line/frame length measurement.
//
//   state    | meaning
//   UNLOCKED | no timing reference yet; counters free-run, no checks
//   CHECK    | aligned on a v_rise, counting clean frames toward lock
//   LOCKED   | timing confirmed; o_Active enabled, wrap without h_rise is an error
module vga_sync_receiver
  import vga_pkg::*;
#(
  parameter int  TOTAL_COLS  = VGA_TOTAL_COLS,
  parameter int  TOTAL_ROWS  = VGA_TOTAL_ROWS,
  parameter int  ACTIVE_COLS = VGA_ACTIVE_COLS,
  parameter int  ACTIVE_ROWS = VGA_ACTIVE_ROWS,
  parameter int  LOCK_FRAMES = 2,
  localparam int CW          = vga_width(TOTAL_COLS),
  localparam int RW          = vga_width(TOTAL_ROWS)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_HSync,
  input  logic          i_VSync,
  output logic [CW-1:0] o_Col_Count,
  output logic [RW-1:0] o_Row_Count,
  output logic          o_Active,
  output logic          o_Frame_Start,
  output logic          o_Locked,
  output logic          o_Sync_Err,
  output logic [7:0]    o_Err_Count,
  output logic [CW:0]   o_Meas_Cols,
  output logic [RW:0]   o_Meas_Rows
);

  localparam int GW = vga_width(LOCK_FRAMES);
  localparam logic [CW-1:0] COL_LAST = CW'(TOTAL_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(TOTAL_ROWS - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

  logic h_rise, v_rise, h_fall_unused, v_fall_unused;

  vga_sync_edge_det u_h_edge (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Sync  (i_HSync),
    .o_Rise  (h_rise),
    .o_Fall  (h_fall_unused)
  );

  vga_sync_edge_det u_v_edge (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Sync  (i_VSync),
    .o_Rise  (v_rise),
    .o_Fall  (v_fall_unused)
  );

  vga_rx_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [GW-1:0] good_q, good_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          sync_err_q, sync_err_d;
  logic          frame_start_q, frame_start_d;

  logic col_last, row_last, violation;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  // v_rise is only legal together with h_rise at the very last pixel of the frame.
  always_comb begin
    violation = 1'b0;
    if (state_q != UNLOCKED) begin
      if (h_rise && !col_last) violation = 1'b1;
      if (v_rise && !(col_last && row_last && h_rise)) violation = 1'b1;
      if (state_q == LOCKED && col_last && !h_rise) violation = 1'b1;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (v_rise) begin
      col_d = '0;
      row_d = '0;
    end else if (h_rise || col_last) begin
      col_d = '0;
      row_d = row_last ? '0 : row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    sync_err_d    = violation;
    frame_start_d = v_rise;
    err_cnt_d     = (violation && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    case (state_q)
      UNLOCKED: begin
        if (v_rise) begin
          state_d = CHECK;
          good_d  = '0;
        end
      end
      CHECK: begin
        if (violation) begin
          state_d = UNLOCKED;
        end else if (v_rise) begin
          if (good_q == GOOD_LAST) state_d = LOCKED;
          else                     good_d  = good_q + 1'b1;
        end
      end
      LOCKED: begin
        if (violation) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= UNLOCKED;
      col_q         <= '0;
      row_q         <= '0;
      good_q        <= '0;
      err_cnt_q     <= '0;
      sync_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      good_q        <= good_d;
      err_cnt_q     <= err_cnt_d;
      sync_err_q    <= sync_err_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Locked      = (state_q == LOCKED);
  assign o_Active      = o_Locked && (col_q < CW'(ACTIVE_COLS)) && (row_q < RW'(ACTIVE_ROWS));
  assign o_Frame_Start = frame_start_q;
  assign o_Sync_Err    = sync_err_q;
  assign o_Err_Count   = err_cnt_q;

`ifdef VGA_RX_MEASURE_EN
  logic [CW:0] line_len_q, line_len_d, meas_cols_q, meas_cols_d;
  logic [RW:0] frame_len_q, frame_len_d, meas_rows_q, meas_rows_d;

  // The h_rise coincident with v_rise is the first line of the new frame.
  always_comb begin
    line_len_d  = (&line_len_q) ? line_len_q : line_len_q + 1'b1;
    meas_cols_d = meas_cols_q;
    if (h_rise) begin
      meas_cols_d = line_len_q;
      line_len_d  = (CW+1)'(1);
    end
    frame_len_d = frame_len_q;
    meas_rows_d = meas_rows_q;
    if (v_rise) begin
      meas_rows_d = frame_len_q;
      frame_len_d = {{RW{1'b0}}, h_rise};
    end else if (h_rise && !(&frame_len_q)) begin
      frame_len_d = frame_len_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      line_len_q  <= '0;
      meas_cols_q <= '0;
      frame_len_q <= '0;
      meas_rows_q <= '0;
    end else begin
      line_len_q  <= line_len_d;
      meas_cols_q <= meas_cols_d;
      frame_len_q <= frame_len_d;
      meas_rows_q <= meas_rows_d;
    end
  end

  assign o_Meas_Cols = meas_cols_q;
  assign o_Meas_Rows = meas_rows_q;
`else
  assign o_Meas_Cols = '0;
  assign o_Meas_Rows = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver using reduced timing and a behavioural reference model.
module tb_vga_sync_receiver;

  localparam int TC = 48;
  localparam int TR = 20;
  localparam int AC = 36;
  localparam int AR = 14;
  localparam int LF = 2;
  localparam int CW = $clog2(TC);
  localparam int RW = $clog2(TR);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hs = 1'b0;
  logic          vs = 1'b0;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          active, frame_start, locked, sync_err;
  logic [7:0]    err_cnt;
  logic [CW:0]   meas_cols;
  logic [RW:0]   meas_rows;

  vga_sync_receiver #(
    .TOTAL_COLS (TC),
    .TOTAL_ROWS (TR),
    .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR),
    .LOCK_FRAMES(LF)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_HSync      (hs),
    .i_VSync      (vs),
    .o_Col_Count  (col_cnt),
    .o_Row_Count  (row_cnt),
    .o_Active     (active),
    .o_Frame_Start(frame_start),
    .o_Locked     (locked),
    .o_Sync_Err   (sync_err),
    .o_Err_Count  (err_cnt),
    .o_Meas_Cols  (meas_cols),
    .o_Meas_Rows  (meas_rows)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // reference model state
  int m_col, m_row, m_good, m_errs;
  bit m_tracking, m_locked, m_serr, m_fs, m_ph, m_pv;
  int edge_n, vr_count, first_vr_edge;

  // sync source state
  int scol, srow, src_tc, src_tr;
  bit hold_h;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_row = 0; m_good = 0; m_errs = 0;
    m_tracking = 0; m_locked = 0; m_serr = 0; m_fs = 0;
    m_ph = 1; m_pv = 1;
  endtask

  task automatic model_step(input bit h, input bit v);
    bit hr, vr, bad, at_end, frame_end;
    hr = h && !m_ph;
    vr = v && !m_pv;
    at_end = (m_col == TC - 1);
    frame_end = at_end && (m_row == TR - 1);
    bad = 0;
    if (m_tracking || m_locked) begin
      if (hr && !at_end) bad = 1;
      if (vr && !(frame_end && hr)) bad = 1;
      if (m_locked && at_end && !hr) bad = 1;
    end
    if (bad) begin
      m_tracking = 0;
      m_locked = 0;
      if (m_errs < 255) m_errs++;
    end else if (vr) begin
      if (!m_tracking && !m_locked) begin
        m_tracking = 1;
        m_good = 0;
      end else if (m_tracking) begin
        m_good++;
        if (m_good == LF) begin
          m_tracking = 0;
          m_locked = 1;
        end
      end
    end
    if (vr) begin
      m_col = 0; m_row = 0;
    end else if (hr) begin
      m_col = 0; m_row = (m_row + 1) % TR;
    end else begin
      m_col = m_col + 1;
      if (m_col == TC) begin
        m_col = 0; m_row = (m_row + 1) % TR;
      end
    end
    m_serr = bad;
    m_fs = vr;
    m_ph = h;
    m_pv = v;
    edge_n++;
    if (vr) begin
      vr_count++;
      if (vr_count == 1) first_vr_edge = edge_n;
    end
  endtask

  task automatic check_all();
    chk("col", col_cnt, m_col);
    chk("row", row_cnt, m_row);
    chk("locked", locked, m_locked);
    chk("sync_err", sync_err, m_serr);
    chk("frame_start", frame_start, m_fs);
    chk("err_count", err_cnt, m_errs);
    chk("active", active, m_locked && m_col < AC && m_row < AR);
    if (m_locked && m_row == AR - 1 && (m_col == AC - 1 || m_col == AC))
      chk("active_col_edge", active, m_col == AC - 1);
    if (m_locked && m_col == 0 && (m_row == AR - 1 || m_row == AR))
      chk("active_row_edge", active, m_row == AR - 1);
`ifndef VGA_RX_MEASURE_EN
    chk("meas_cols_tied", meas_cols, 0);
    chk("meas_rows_tied", meas_rows, 0);
`endif
  endtask

  task automatic tick(input bit h, input bit v);
    hs = h;
    vs = v;
    @(posedge clk);
    if (rst_n) model_step(h, v);
    #1;
    check_all();
  endtask

  task automatic src_step();
    bit h, v;
    h = (scol < AC) || hold_h;
    v = (srow < AR);
    tick(h, v);
    scol++;
    if (scol >= src_tc) begin
      scol = 0;
      srow++;
      if (srow >= src_tr) srow = 0;
    end
  endtask

  task automatic run_until_locked(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      src_step();
      if (locked === 1'b1) break;
    end
    chk(tag, locked, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    src_tc = TC; src_tr = TR; hold_h = 0;
    scol = $urandom_range(TC - 1);
    srow = $urandom_range(TR - 2, 1);
    hs = (scol < AC); vs = (srow < AR);
    model_reset();
    edge_n = 0; vr_count = 0; first_vr_edge = 0;
    #12;
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // lock from a mid-frame release
    for (int i = 0; i < 4 * TC * TR; i++) begin
      src_step();
      if (locked === 1'b1) break;
    end
    chk("lock_vrises", vr_count, 3);
    chk("lock_distance", edge_n - first_vr_edge, 2 * TC * TR);
    chk("lock_errs", err_cnt, 0);

    // frame alignment at a v_rise
    for (int i = 0; i < TC * TR + 4; i++) begin
      src_step();
      if (m_fs) break;
    end
    chk("align_col", col_cnt, 0);
    chk("align_row", row_cnt, 0);
    chk("align_fs", frame_start, 1);
    repeat (TC * TR) src_step();

    // short line: next h_rise arrives one clock early
    r = $urandom_range(AR - 3, 1);
    for (int i = 0; i < 2 * TC * TR; i++) begin
      if (scol == TC - 1 && srow == r) break;
      src_step();
    end
    scol = 0;
    srow++;
    src_step();
    chk("short_err", sync_err, 1);
    chk("short_locked", locked, 0);
    chk("short_errcnt", err_cnt, 1);
    chk("short_col", col_cnt, 0);
    run_until_locked("short_relock", 5 * TC * TR);

    // missing HSync: held high across one line boundary
    r = $urandom_range(AR - 3, 1);
    for (int i = 0; i < 2 * TC * TR; i++) begin
      if (scol == 0 && srow == r) break;
      src_step();
    end
    hold_h = 1;
    repeat (TC) src_step();
    hold_h = 0;
    src_step();
    chk("miss_err", sync_err, 1);
    chk("miss_locked", locked, 0);
    chk("miss_errcnt", err_cnt, 2);
    vr_count = 0;
    run_until_locked("miss_relock", 5 * TC * TR);
    chk("miss_relock_vrises", vr_count, 3);

    // random sync activity, then recover
    repeat (300) tick(1'($urandom_range(1)), 1'($urandom_range(1)));
    run_until_locked("random_relock", 6 * TC * TR);

    // error counter saturation
    repeat (270) begin
      tick(0, 0);
      tick(1, 1);
      tick(0, 0);
      tick(1, 0);
    end
    chk("sat_errcnt", err_cnt, 255);

    // asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    chk("rst_col", col_cnt, 0);
    chk("rst_row", row_cnt, 0);
    chk("rst_locked", locked, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_active", active, 0);
    chk("rst_meas_cols", meas_cols, 0);
    chk("rst_meas_rows", meas_rows, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // off-nominal source: longer lines and taller frames
    src_tc = TC + 10; src_tr = TR + 5;
    scol = 0; srow = 0;
    repeat (3 * src_tc * src_tr) src_step();
`ifdef VGA_RX_MEASURE_EN
    chk("meas_cols", meas_cols, TC + 10);
    chk("meas_rows", meas_rows, TR + 5);
`else
    chk("meas_cols_off", meas_cols, 0);
    chk("meas_rows_off", meas_rows, 0);
`endif
    chk("meas_nolock", locked, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
